// File: rtl/stack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stack_ctrl
//  Description : Stack and error side-channel responder for the class-10
//                instruction decoder. Owns the stack count, sequences one
//                data-memory access per push/pop and latches the first error
//                into a sticky halt register.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Optional feature macro:
//    STACK_CTRL_HIGHWATER_EN  adds output SC_Max, the highest SC reached
//                             since reset or Err_Clr.
// ----------------------------------------------------------------------------
//  Ports:
//    CLK       in   1     system clock, rising edge
//    RST       in   1     synchronous active-high reset
//    ID_Valid  in   1     qualifies SCN / ER_CDE
//    SCN       in   2     00 none, 01 push, 10 pop, 11 illegal
//    ER_CDE    in   8     decoder error code, 0 = no error
//    Err_Clr   in   1     clears halt and error code
//    SC        out  SC_W  current stack count
//    SP_Ad     out  16    stack slot address of the current access
//    Mem_WE    out  1     data-memory write strobe (push)
//    Mem_RE    out  1     data-memory read strobe (pop)
//    Busy      out  1     stack access in flight
//    Halt      out  1     sticky error halt
//    Err_Code  out  8     first latched error code
//    SC_Max    out  SC_W  high-water mark (STACK_CTRL_HIGHWATER_EN only)
// ============================================================================

module stack_ctrl #(
    parameter int          SC_W      = 3,
    parameter logic [15:0] STACK_TOP = 16'h00FF
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ID_Valid,
    input  logic [1:0]      SCN,
    input  logic [7:0]      ER_CDE,
    input  logic            Err_Clr,
    output logic [SC_W-1:0] SC,
    output logic [15:0]     SP_Ad,
    output logic            Mem_WE,
    output logic            Mem_RE,
    output logic            Busy,
    output logic            Halt,
    output logic [7:0]      Err_Code
`ifdef STACK_CTRL_HIGHWATER_EN
    ,
    output logic [SC_W-1:0] SC_Max
`endif
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] SCN_NONE    = 2'b00;
    localparam logic [1:0] SCN_PUSH    = 2'b01;
    localparam logic [1:0] SCN_POP     = 2'b10;
    localparam logic [1:0] SCN_ILLEGAL = 2'b11;

    localparam logic [7:0] ERR_OVERFLOW  = 8'h03;
    localparam logic [7:0] ERR_UNDERFLOW = 8'h04;
    localparam logic [7:0] ERR_ILLEGAL   = 8'h07;

    localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);
    localparam logic [SC_W-1:0] SC_FULL = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PUSH = 2'd1,
        ST_POP  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_q,    state_d;
    logic [SC_W-1:0]   sc_q,       sc_d;
    logic [15:0]       sp_ad_q,    sp_ad_d;
    logic              mem_we_q,   mem_we_d;
    logic              mem_re_q,   mem_re_d;
    logic              busy_q,     busy_d;
    logic              halt_q,     halt_d;
    logic [7:0]        err_code_q, err_code_d;

    // ------------------------------------------------------------------
    // Address arithmetic: SC zero-extended to 16 bits so the slot
    // addresses match the decoder's literal calculation.
    // ------------------------------------------------------------------
    logic [15:0]     sc_ext;
    logic [15:0]     push_addr;
    logic [15:0]     pop_addr;
    logic [SC_W-1:0] sc_inc;
    logic [SC_W-1:0] sc_dec;

    assign sc_ext    = {{(16-SC_W){1'b0}}, sc_q};
    assign push_addr = STACK_TOP - sc_ext;
    assign pop_addr  = STACK_TOP + 16'd1 - sc_ext;
    assign sc_inc    = sc_q + SC_ONE;
    assign sc_dec    = sc_q - SC_ONE;

`ifdef STACK_CTRL_HIGHWATER_EN
    logic [SC_W-1:0] sc_max_q, sc_max_d;
`endif

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        sc_d       = sc_q;
        sp_ad_d    = sp_ad_q;
        mem_we_d   = 1'b0;
        mem_re_d   = 1'b0;
        busy_d     = 1'b0;
        halt_d     = halt_q;
        err_code_d = err_code_q;
`ifdef STACK_CTRL_HIGHWATER_EN
        sc_max_d   = sc_max_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (ID_Valid) begin
                    if (ER_CDE != 8'h00) begin
                        // Decoder-reported error wins over any stack request.
                        err_code_d = ER_CDE;
                        halt_d     = 1'b1;
                        state_d    = ST_HALT;
                    end else if (SCN == SCN_ILLEGAL) begin
                        err_code_d = ERR_ILLEGAL;
                        halt_d     = 1'b1;
                        state_d    = ST_HALT;
                    end else if ((SCN == SCN_PUSH) && (sc_q == SC_FULL)) begin
                        err_code_d = ERR_OVERFLOW;
                        halt_d     = 1'b1;
                        state_d    = ST_HALT;
                    end else if ((SCN == SCN_POP) && (sc_q == '0)) begin
                        err_code_d = ERR_UNDERFLOW;
                        halt_d     = 1'b1;
                        state_d    = ST_HALT;
                    end else if (SCN == SCN_PUSH) begin
                        sp_ad_d  = push_addr;
                        mem_we_d = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = ST_PUSH;
                    end else if (SCN == SCN_POP) begin
                        sp_ad_d  = pop_addr;
                        mem_re_d = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = ST_POP;
                    end else begin
                        // SCN_NONE: nothing to do.
                        state_d = ST_IDLE;
                    end
                end
            end

            // The strobe was driven during this cycle; commit the count as
            // the access completes.
            ST_PUSH: begin
                sc_d    = sc_inc;
                state_d = ST_IDLE;
`ifdef STACK_CTRL_HIGHWATER_EN
                if (sc_inc > sc_max_q) begin
                    sc_max_d = sc_inc;
                end
`endif
            end

            ST_POP: begin
                sc_d    = sc_dec;
                state_d = ST_IDLE;
            end

            ST_HALT: begin
                // Requests are ignored and SC is frozen until Err_Clr.
                halt_d = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Err_Clr overrides everything, including a request sampled in the
        // same cycle: that request is dropped and SP_Ad keeps its value.
        if (Err_Clr) begin
            err_code_d = 8'h00;
            halt_d     = 1'b0;
            state_d    = ST_IDLE;
            sp_ad_d    = sp_ad_q;
            mem_we_d   = 1'b0;
            mem_re_d   = 1'b0;
            busy_d     = 1'b0;
`ifdef STACK_CTRL_HIGHWATER_EN
            sc_max_d   = '0;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            sc_q       <= '0;
            sp_ad_q    <= STACK_TOP;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
            busy_q     <= 1'b0;
            halt_q     <= 1'b0;
            err_code_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            sc_q       <= sc_d;
            sp_ad_q    <= sp_ad_d;
            mem_we_q   <= mem_we_d;
            mem_re_q   <= mem_re_d;
            busy_q     <= busy_d;
            halt_q     <= halt_d;
            err_code_q <= err_code_d;
        end
    end

`ifdef STACK_CTRL_HIGHWATER_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            sc_max_q <= '0;
        end else begin
            sc_max_q <= sc_max_d;
        end
    end

    assign SC_Max = sc_max_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign SC       = sc_q;
    assign SP_Ad    = sp_ad_q;
    assign Mem_WE   = mem_we_q;
    assign Mem_RE   = mem_re_q;
    assign Busy     = busy_q;
    assign Halt     = halt_q;
    assign Err_Code = err_code_q;

endmodule

`default_nettype wire
